sdc_rd_byte_packer: RTL
=======================

Name: sdc_rd_byte_packer

Overview:
Upstream feeder for the 2048x64 dual-port read-data buffer in the SD card read path. Takes the deserialized DAT-line byte stream for a multi-block read and packs every 8 bytes into one 64-bit word. Each packed word is written through buffer port A at an incrementing address. The block also tracks 512-byte block boundaries, per-block CRC status and transfer completion for the read controller.

Parameters:
MSB_FIRST, 1, 1: first byte of each word lands in bits [63:56]; 0: first byte lands in bits [7:0]
BLK_WORDS, 64, 64-bit words per SD block (512 bytes / 8)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that arms a transfer; sampled only in IDLE
start_addr  in  11  buffer word address of the first word
num_blks  in  6  blocks to receive, 1..32; 0 means done immediately
abort  in  1  synchronous cancel of the current transfer
byte_in  in  8  received data byte
byte_vld  in  1  byte_in valid for one cycle
crc_vld  in  1  one-cycle pulse: CRC check result for the block just received
crc_ok  in  1  CRC result, qualified by crc_vld
bram_addr  out  11  buffer port A address
bram_din  out  64  buffer port A write data
bram_wr  out  1  buffer port A write strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the transfer completes
crc_err  out  1  sticky; set when any block in the transfer has a bad CRC; cleared on accepted start
byte_drop  out  1  one-cycle pulse when byte_vld arrives outside RECV

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte, word and block counters 0.
- States: IDLE, RECV, WAIT_CRC, DONE.
- IDLE:
  - start=1 latches start_addr into the address counter and num_blks into the remaining-block counter, and clears crc_err.
  - Next state is RECV, or DONE if num_blks=0.
  - start in any other state is ignored.
- RECV:
  - Each byte_vld shifts byte_in into the pack register at byte index 0..7, per MSB_FIRST.
  - On the 8th byte, the cycle after it is accepted: bram_wr=1 for exactly one cycle, bram_din=packed word, bram_addr=current address.
  - The address increments after the write and wraps 2047 -> 0.
  - The byte index returns to 0, and a byte arriving in the write cycle is accepted into the next word (no stall, no loss).
  - After word BLK_WORDS-1 is written: go to WAIT_CRC.
- WAIT_CRC:
  - On crc_vld, decrement the remaining-block counter; crc_ok=0 sets crc_err.
  - Remaining count reaching 0 -> DONE; otherwise -> RECV, with the word count reset and the address continuing (no gap).
  - crc_vld outside WAIT_CRC is ignored.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle the state returns to IDLE.
- byte_vld in IDLE, WAIT_CRC or DONE: the byte is discarded and byte_drop=1 on the next cycle.
- abort (any non-IDLE state):
  - Next state IDLE; no done pulse.
  - A partial word is discarded and never written; a write already scheduled for this cycle still completes.
  - crc_err holds its value.
- abort and start in the same cycle while IDLE: start wins.
- Bad-CRC blocks are still written to the buffer; the consumer decides via crc_err.
- Throughput: 1 byte/cycle sustained; at most 1 write per 8 accepted bytes.

Test Plan:
- Single block: start_addr=0x010, num_blks=1, MSB_FIRST=1, bytes 0x00..0xFF,0x00..0xFF back-to-back, crc_ok=1 -> 64 writes at 0x010..0x04F, first bram_din=0x0001020304050607, done pulse, crc_err=0.
- Wrap and gaps: start_addr=0x7FC, num_blks=2, random gaps between bytes -> addresses run 0x7FC..0x7FF, then 0x000..0x07B, 128 writes total, contiguous, single done.
- CRC failure: num_blks=3, second block crc_ok=0 -> all 192 words written, crc_err=1 after block 2 and still 1 at done; next start clears it.
- Abort mid-word: abort after 1 full word + 5 bytes -> exactly 1 write, state IDLE, busy=0, no done. A fresh start then begins at its new start_addr with byte index 0.
- Stray traffic: byte_vld in IDLE and WAIT_CRC -> byte_drop pulses, no bram_wr; crc_vld in RECV has no effect. num_blks=0 -> done one cycle after DONE entry, no writes.
- Reset mid-transfer: reset_n low during RECV -> outputs 0 immediately (async), state IDLE after release.

Source files
------------

// File: rtl/sdc_rd_byte_packer.sv
// Packs the SD read-path DAT byte stream into 64-bit words for the read-data buffer,
// tracking block boundaries, per-block CRC status and transfer completion.
module sdc_rd_byte_packer #(
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned BLK_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] start_addr,
    input  logic [5:0]  num_blks,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    input  logic        crc_vld,
    input  logic        crc_ok,
    output logic [10:0] bram_addr,
    output logic [63:0] bram_din,
    output logic        bram_wr,
    output logic        busy,
    output logic        done,
    output logic        crc_err,
    output logic        byte_drop
);

    localparam int unsigned WcW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRecv, StWaitCrc, StDone} state_e;

    state_e         state_q, state_d;
    logic [10:0]    addr_q, addr_d;
    logic [5:0]     blks_q, blks_d;
    logic [2:0]     idx_q, idx_d;
    logic [WcW-1:0] wcnt_q, wcnt_d;
    logic [63:0]    pack_q, pack_d;
    logic [63:0]    din_q, din_d;
    logic           wr_q, wr_d;
    logic           crc_err_q, crc_err_d;
    logic           drop_q, drop_d;

    logic [2:0]     lane;
    logic [63:0]    pack_ins;

    always_comb begin
        lane     = MSB_FIRST ? (3'd7 - idx_q) : idx_q;
        pack_ins = pack_q;
        pack_ins[{lane, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = wr_q ? (addr_q + 11'd1) : addr_q;
        blks_d    = blks_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        pack_d    = pack_q;
        din_d     = din_q;
        wr_d      = 1'b0;
        crc_err_d = crc_err_q;
        drop_d    = byte_vld && (state_q != StRecv);

        unique case (state_q)
            StIdle: begin
                // start wins over a coincident abort here
                if (start) begin
                    addr_d    = start_addr;
                    blks_d    = num_blks;
                    crc_err_d = 1'b0;
                    idx_d     = 3'd0;
                    wcnt_d    = '0;
                    state_d   = (num_blks == 6'd0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (abort) begin
                    idx_d   = 3'd0;
                    wcnt_d  = '0;
                    state_d = StIdle;
                end else if (byte_vld) begin
                    pack_d = pack_ins;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        wr_d  = 1'b1;
                        din_d = pack_ins;
                        if (wcnt_q == WcW'(BLK_WORDS - 1)) begin
                            wcnt_d  = '0;
                            state_d = StWaitCrc;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
            end
            StWaitCrc: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (crc_vld) begin
                    blks_d = blks_q - 6'd1;
                    if (!crc_ok) crc_err_d = 1'b1;
                    state_d = (blks_q <= 6'd1) ? StDone : StRecv;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            blks_q    <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            pack_q    <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            crc_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            blks_q    <= blks_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            pack_q    <= pack_d;
            din_q     <= din_d;
            wr_q      <= wr_d;
            crc_err_q <= crc_err_d;
            drop_q    <= drop_d;
        end
    end

    // addr_q holds the write address during the write cycle and advances afterwards
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_wr   = wr_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign crc_err   = crc_err_q;
    assign byte_drop = drop_q;

endmodule
